// File: rtl/data_ram_pkg.sv
// rtl/data_ram_pkg.sv - shared widths, op encodings and state encoding for the data RAM port
package data_ram_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int ADDR_WIDTH  = 10;
    localparam int MEM_WORDS   = 121;
    localparam int MAX_BURST   = 8;
    localparam int COUNT_WIDTH = 4;

    typedef enum logic [1:0] {
        OP_LOAD     = 2'b00,
        OP_STORE    = 2'b01,
        OP_FILL     = 2'b10,
        OP_RESERVED = 2'b11
    } reqOp_t;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        RESP,
        FAULT
    } unitState_t;

endpackage

// File: rtl/data_ram_bounds_check.sv
// rtl/data_ram_bounds_check.sv - effective address and range/op legality check for one request
module data_ram_bounds_check
    import data_ram_pkg::*;
(
    input  logic [ADDR_WIDTH-1:0]  base,
    input  logic [ADDR_WIDTH-1:0]  offset,
    input  logic [COUNT_WIDTH-1:0] count,
    input  logic [1:0]             op,
    output logic [ADDR_WIDTH-1:0]  ea,
    output logic                   fault
);

    localparam int AW1 = ADDR_WIDTH + 1;
    localparam logic [AW1-1:0] LAST_WORD = AW1'(MEM_WORDS - 1);

    logic           isBurst;
    logic           countBad;
    logic [AW1-1:0] lastAddr;

    // The burst end is computed one bit wider so an end past 2^ADDR_WIDTH cannot alias low.
    always_comb begin
        ea       = base + offset;
        isBurst  = (op == OP_LOAD) || (op == OP_FILL);
        countBad = (count == '0) || (count > COUNT_WIDTH'(MAX_BURST));
        lastAddr = {1'b0, ea} + AW1'(count) - AW1'(1);
        fault    = (op == OP_RESERVED)
                || ({1'b0, ea} > LAST_WORD)
                || (isBurst && (countBad || (lastAddr > LAST_WORD)));
    end

endmodule

// File: rtl/data_ram_access_unit.sv
// rtl/data_ram_access_unit.sv - load/store/fill initiator for the data RAM with streamed load responses
module data_ram_access_unit
    import data_ram_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   reqValid,
    output logic                   reqReady,
    input  logic [1:0]             reqOp,
    input  logic [ADDR_WIDTH-1:0]  reqBase,
    input  logic [ADDR_WIDTH-1:0]  reqOffset,
    input  logic [COUNT_WIDTH-1:0] reqCount,
    input  logic [DATA_WIDTH-1:0]  reqData,
    output logic                   respValid,
    input  logic                   respReady,
    output logic [DATA_WIDTH-1:0]  respData,
    output logic                   respLast,
    output logic                   done,
    output logic                   fault,
    output logic [DATA_WIDTH-1:0]  ramDataC,
    output logic [ADDR_WIDTH-1:0]  ramAddress,
    output logic                   ramWriteEnable,
    input  logic [DATA_WIDTH-1:0]  ramDataOutput
);

    unitState_t             state, stateNext;
    logic [COUNT_WIDTH-1:0] remaining, remainingNext;
    logic [ADDR_WIDTH-1:0]  addressNext;
    logic [DATA_WIDTH-1:0]  writeDataNext;
    logic                   writeEnableNext;
    logic [DATA_WIDTH-1:0]  respDataNext;
    logic                   respValidNext;
    logic                   respLastNext;
    logic                   doneNext;
    logic                   faultNext;
    logic [ADDR_WIDTH-1:0]  ea;
    logic                   checkFault;

    data_ram_bounds_check u_boundsCheck (
        .base   (reqBase),
        .offset (reqOffset),
        .count  (reqCount),
        .op     (reqOp),
        .ea     (ea),
        .fault  (checkFault)
    );

    assign reqReady = (state == IDLE);

    always_comb begin
        stateNext       = state;
        remainingNext   = remaining;
        addressNext     = ramAddress;
        writeDataNext   = ramDataC;
        writeEnableNext = 1'b0;
        respDataNext    = respData;
        respValidNext   = respValid;
        respLastNext    = respLast;
        doneNext        = 1'b0;
        faultNext       = 1'b0;

        unique case (state)
            IDLE: begin
                if (reqValid) begin
                    if (checkFault) begin
                        stateNext = FAULT;
                    end else begin
                        addressNext   = ea;
                        writeDataNext = reqData;
                        // A store is a one-word fill; its count input is don't-care.
                        remainingNext = (reqOp == OP_STORE) ? COUNT_WIDTH'(1) : reqCount;
                        if (reqOp == OP_LOAD) begin
                            stateNext = READ;
                        end else begin
                            writeEnableNext = 1'b1;
                            stateNext       = WRITE;
                        end
                    end
                end
            end
            WRITE: begin
                if (remaining > COUNT_WIDTH'(1)) begin
                    writeEnableNext = 1'b1;
                    addressNext     = ramAddress + ADDR_WIDTH'(1);
                    remainingNext   = remaining - COUNT_WIDTH'(1);
                end else begin
                    doneNext  = 1'b1;
                    stateNext = IDLE;
                end
            end
            READ: begin
                respDataNext  = ramDataOutput;
                respValidNext = 1'b1;
                respLastNext  = (remaining == COUNT_WIDTH'(1));
                stateNext     = RESP;
            end
            RESP: begin
                if (respReady) begin
                    respValidNext = 1'b0;
                    respLastNext  = 1'b0;
                    if (remaining > COUNT_WIDTH'(1)) begin
                        addressNext   = ramAddress + ADDR_WIDTH'(1);
                        remainingNext = remaining - COUNT_WIDTH'(1);
                        stateNext     = READ;
                    end else begin
                        doneNext  = 1'b1;
                        stateNext = IDLE;
                    end
                end
            end
            FAULT: begin
                doneNext  = 1'b1;
                faultNext = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            remaining      <= '0;
            ramAddress     <= '0;
            ramDataC       <= '0;
            ramWriteEnable <= 1'b0;
            respData       <= '0;
            respValid      <= 1'b0;
            respLast       <= 1'b0;
            done           <= 1'b0;
            fault          <= 1'b0;
        end else begin
            state          <= stateNext;
            remaining      <= remainingNext;
            ramAddress     <= addressNext;
            ramDataC       <= writeDataNext;
            ramWriteEnable <= writeEnableNext;
            respData       <= respDataNext;
            respValid      <= respValidNext;
            respLast       <= respLastNext;
            done           <= doneNext;
            fault          <= faultNext;
        end
    end

endmodule
